// File: rtl/game_scorer.sv
// Rhythm-game scorer: start-edge FSM (IDLE/READY/PLAY/OVER) with hit/miss scoring.
// Macro SCORER_COMBO_EN enables the streak-based score multiplier (1..4).
module game_scorer #(
    parameter int READY_CYCLES = 100000000,
    parameter int BASE_POINTS  = 10,
    parameter int SCORE_MAX    = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        strum,
    input  logic [3:0]  btn,
    input  logic [3:0]  note_lane,
    input  logic        time_up,
    output logic [1:0]  gamestate,
    output logic [15:0] score,
    output logic [7:0]  streak,
    output logic        hit_pulse,
    output logic        miss_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READY = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam int CW = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;
    localparam logic [CW-1:0] RDY_LAST = CW'(READY_CYCLES - 1);
    localparam logic [17:0] SMAX = 18'(SCORE_MAX);
    localparam logic [17:0] BASE = 18'(BASE_POINTS);

    state_t        state_q, state_d;
    logic          start_q, start_d;
    logic          start_prev_q, start_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   score_q, score_d;
    logic [7:0]    streak_q, streak_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;

    logic          start_rise;
    logic          is_hit;
    logic [2:0]    mult;
    logic [17:0]   sum;
    logic [15:0]   score_sat;
    logic [7:0]    streak_inc;

    // Start button edge detector: two-stage history of the start level.
    always_comb begin
        start_d      = start;
        start_prev_d = start_q;
        start_rise   = start_q & ~start_prev_q;
    end

    // Hit classification: lane pattern must match exactly and be non-empty.
    always_comb begin
        is_hit = (note_lane != 4'b0000) && (btn == note_lane);
    end

    // Multiplier from the streak value held before this hit is counted.
    always_comb begin
`ifdef SCORER_COMBO_EN
        if ((streak_q[7:5] != 3'b000) || (streak_q[4:3] == 2'b11)) begin
            mult = 3'd4;
        end else begin
            mult = {1'b0, streak_q[4:3]} + 3'd1;
        end
`else
        mult = 3'd1;
`endif
    end

    // Widened score add with exact saturation; streak saturating increment.
    always_comb begin
        sum        = {2'b00, score_q} + (BASE * {15'd0, mult});
        score_sat  = (sum > SMAX) ? SMAX[15:0] : sum[15:0];
        streak_inc = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;
    end

    // Next-state, counter and scoring logic for the game phases.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        score_d  = score_q;
        streak_d = streak_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d  = ST_READY;
                    cnt_d    = '0;
                    score_d  = '0;
                    streak_d = '0;
                end
            end
            ST_READY: begin
                if (cnt_q == RDY_LAST) begin
                    state_d = ST_PLAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PLAY: begin
                if (time_up) begin
                    state_d = ST_OVER;
                end else if (strum) begin
                    if (is_hit) begin
                        streak_d = streak_inc;
                        score_d  = score_sat;
                        hit_d    = 1'b1;
                    end else begin
                        streak_d = '0;
                        miss_d   = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            cnt_q        <= '0;
            score_q      <= '0;
            streak_q     <= '0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            start_prev_q <= start_prev_d;
            cnt_q        <= cnt_d;
            score_q      <= score_d;
            streak_q     <= streak_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        gamestate  = state_q;
        score      = score_q;
        streak     = streak_q;
        hit_pulse  = hit_q;
        miss_pulse = miss_q;
    end

endmodule

// File: tb/tb_game_scorer.sv
// Directed self-checking bench for game_scorer.
// Second instance (BASE_POINTS=5) exercises score and streak saturation.
module tb_game_scorer;

`ifdef SCORER_COMBO_EN
    localparam int EXP9 = 100;
`else
    localparam int EXP9 = 90;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start, strum, time_up;
    logic [3:0]  btn, note_lane;
    logic [1:0]  gamestate;
    logic [15:0] score;
    logic [7:0]  streak;
    logic        hit_pulse, miss_pulse;

    logic        start2, strum2, time_up2;
    logic [3:0]  btn2, note2;
    logic [1:0]  gamestate2;
    logic [15:0] score2;
    logic [7:0]  streak2;
    logic        hit2, miss2;

    int tests = 0;
    int fails = 0;
    int exp_score;

    always #5 clk = ~clk;

    game_scorer #(.READY_CYCLES(4), .BASE_POINTS(10), .SCORE_MAX(9999)) dut (
        .clk(clk), .reset(reset), .start(start), .strum(strum),
        .btn(btn), .note_lane(note_lane), .time_up(time_up),
        .gamestate(gamestate), .score(score), .streak(streak),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    game_scorer #(.READY_CYCLES(4), .BASE_POINTS(5), .SCORE_MAX(9999)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .strum(strum2),
        .btn(btn2), .note_lane(note2), .time_up(time_up2),
        .gamestate(gamestate2), .score(score2), .streak(streak2),
        .hit_pulse(hit2), .miss_pulse(miss2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 0; strum = 0; time_up = 0; btn = 0; note_lane = 0;
        start2 = 0; strum2 = 0; time_up2 = 0; btn2 = 0; note2 = 0;
        tick();
        tick();
        tests++;
        if (gamestate !== 2'b00) begin
            fails++; $display("FAIL rst_state got %b exp 00", gamestate);
        end
        tests++;
        if (score !== 16'd0 || streak !== 8'd0) begin
            fails++; $display("FAIL rst_score got %0d/%0d exp 0/0", score, streak);
        end
        tests++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
            fails++; $display("FAIL rst_pulse got %b%b exp 00", hit_pulse, miss_pulse);
        end
        tests++;
        if (gamestate2 !== 2'b00 || score2 !== 16'd0) begin
            fails++; $display("FAIL rst_dut2 got %b/%0d exp 00/0", gamestate2, score2);
        end
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_start_ready();
        start = 1'b1;
        tick();
        tests++;
        if (gamestate !== 2'b00) begin
            fails++; $display("FAIL start_lat got %b exp 00", gamestate);
        end
        tick();
        start = 1'b0;
        tests++;
        if (gamestate !== 2'b01 || score !== 16'd0) begin
            fails++; $display("FAIL ready_entry got %b/%0d exp 01/0", gamestate, score);
        end
        strum = 1'b1; btn = 4'b0101; note_lane = 4'b0101;
        tick();
        strum = 1'b0;
        tests++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || score !== 16'd0) begin
            fails++; $display("FAIL ready_strum got %b%b/%0d exp 00/0", hit_pulse, miss_pulse, score);
        end
        tick();
        tick();
        tests++;
        if (gamestate !== 2'b01) begin
            fails++; $display("FAIL ready_hold got %b exp 01", gamestate);
        end
        tick();
        tests++;
        if (gamestate !== 2'b10 || score !== 16'd0) begin
            fails++; $display("FAIL play_entry got %b/%0d exp 10/0", gamestate, score);
        end
    endtask

    task automatic test_hit();
        strum = 1'b1; btn = 4'b0101; note_lane = 4'b0101;
        tick();
        strum = 1'b0;
        exp_score = 10;
        tests++;
        if (score !== 16'(exp_score) || streak !== 8'd1 || hit_pulse !== 1'b1 || miss_pulse !== 1'b0) begin
            fails++;
            $display("FAIL hit got s=%0d k=%0d h=%b m=%b exp 10/1/1/0", score, streak, hit_pulse, miss_pulse);
        end
        tick();
        tests++;
        if (hit_pulse !== 1'b0) begin
            fails++; $display("FAIL hit_width got %b exp 0", hit_pulse);
        end
    endtask

    task automatic test_combo();
        strum = 1'b1; btn = 4'b0001; note_lane = 4'b0000;
        tick();
        strum = 1'b0;
        tests++;
        if (miss_pulse !== 1'b1 || streak !== 8'd0 || score !== 16'(exp_score)) begin
            fails++;
            $display("FAIL ghost got m=%b k=%0d s=%0d exp 1/0/%0d", miss_pulse, streak, score, exp_score);
        end
        btn = 4'b1000; note_lane = 4'b1000;
        for (int i = 0; i < 9; i++) begin
            strum = 1'b1;
            tick();
        end
        strum = 1'b0;
        exp_score = exp_score + EXP9;
        tests++;
        if (score !== 16'(exp_score) || streak !== 8'd9) begin
            fails++;
            $display("FAIL combo9 got s=%0d k=%0d exp %0d/9", score, streak, exp_score);
        end
        tick();
    endtask

    task automatic test_miss();
        strum = 1'b1; btn = 4'b0001; note_lane = 4'b0100;
        tick();
        btn = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        exp_score = exp_score + 50;
        strum = 1'b0;
        tests++;
        if (streak !== 8'd5 || score !== 16'(exp_score)) begin
            fails++;
            $display("FAIL pre_miss got k=%0d s=%0d exp 5/%0d", streak, score, exp_score);
        end
        strum = 1'b1; btn = 4'b0011; note_lane = 4'b0010;
        tick();
        strum = 1'b0;
        tests++;
        if (streak !== 8'd0 || score !== 16'(exp_score) || miss_pulse !== 1'b1 || hit_pulse !== 1'b0) begin
            fails++;
            $display("FAIL miss got k=%0d s=%0d m=%b h=%b exp 0/%0d/1/0", streak, score, miss_pulse, hit_pulse, exp_score);
        end
        tick();
        tests++;
        if (miss_pulse !== 1'b0) begin
            fails++; $display("FAIL miss_width got %b exp 0", miss_pulse);
        end
    endtask

    task automatic test_timeup();
        strum = 1'b1; time_up = 1'b1; btn = 4'b0101; note_lane = 4'b0101;
        tick();
        strum = 1'b0; time_up = 1'b0;
        tests++;
        if (gamestate !== 2'b11 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || score !== 16'(exp_score)) begin
            fails++;
            $display("FAIL timeup got %b h=%b m=%b s=%0d exp 11/0/0/%0d", gamestate, hit_pulse, miss_pulse, score, exp_score);
        end
        strum = 1'b1;
        tick();
        strum = 1'b0;
        tests++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
            fails++; $display("FAIL over_strum got %b%b exp 00", hit_pulse, miss_pulse);
        end
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tests++;
        if (gamestate !== 2'b00 || score !== 16'(exp_score)) begin
            fails++;
            $display("FAIL over_idle got %b/%0d exp 00/%0d", gamestate, score, exp_score);
        end
        tick();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tests++;
        if (gamestate !== 2'b01 || score !== 16'd0 || streak !== 8'd0) begin
            fails++;
            $display("FAIL restart got %b/%0d/%0d exp 01/0/0", gamestate, score, streak);
        end
    endtask

    task automatic test_reset_abort();
        tick();
        #2 reset = 1'b1;
        #1;
        tests++;
        if (gamestate !== 2'b00 || score !== 16'd0 || streak !== 8'd0) begin
            fails++;
            $display("FAIL abort got %b/%0d/%0d exp 00/0/0", gamestate, score, streak);
        end
        tick();
        #2 reset = 1'b0;
        tick();
        tests++;
        if (gamestate !== 2'b00) begin
            fails++; $display("FAIL abort_hold got %b exp 00", gamestate);
        end
    endtask

    task automatic test_saturation();
        start2 = 1'b1;
        tick();
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        tests++;
        if (gamestate2 !== 2'b10) begin
            fails++; $display("FAIL sat_play got %b exp 10", gamestate2);
        end
        note2 = 4'b1000;
        strum2 = 1'b1;
        for (int g = 0; g < 249; g++) begin
            btn2 = 4'b1000;
            for (int i = 0; i < 8; i++) begin
                tick();
            end
            btn2 = 4'b0001;
            tick();
        end
        btn2 = 4'b1000;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        strum2 = 1'b0;
        tests++;
        if (score2 !== 16'd9995 || streak2 !== 8'd7) begin
            fails++;
            $display("FAIL sat_pre got %0d/%0d exp 9995/7", score2, streak2);
        end
        strum2 = 1'b1;
        tick();
        strum2 = 1'b0;
        tests++;
        if (score2 !== 16'd9999 || hit2 !== 1'b1) begin
            fails++;
            $display("FAIL sat_hit got %0d h=%b exp 9999/1", score2, hit2);
        end
        strum2 = 1'b1;
        for (int i = 0; i < 250; i++) begin
            tick();
        end
        strum2 = 1'b0;
        tests++;
        if (score2 !== 16'd9999 || streak2 !== 8'd255) begin
            fails++;
            $display("FAIL sat_hold got %0d/%0d exp 9999/255", score2, streak2);
        end
    endtask

    initial begin
        test_reset();
        test_start_ready();
        test_hit();
        test_combo();
        test_miss();
        test_timeup();
        test_reset_abort();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
